// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the multi-domain reset sequencer.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ASSERT,
      WAIT_LOCK,
      RELEASE,
      RUN
   } state_t;

   localparam int LOSS_CNT_W = 8;

   // Wide enough to hold the larger of the two terminal counts without wrapping.
   function automatic int cnt_width(input int lock_cycles, input int gap_cycles);
      int m;
      m = (lock_cycles > gap_cycles) ? lock_cycles : gap_cycles;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rst_seq_bit_syn.sv
// Generic 2-flop synchroniser, async active-low reset to 0.
module bit_syn (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rst_seq.sv
// Multi-domain reset sequencer: qualifies PLL lock, then releases domains in order.
// Optional lock-loss counter output enabled by RST_SEQ_LOSS_CNT_EN.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ASSERT    | all domains held in reset for GAP_CYCLES minimum
//   WAIT_LOCK | counting consecutive synchronised-lock cycles
//   RELEASE   | releasing domains one per GAP_CYCLES, bit 0 first
//   RUN       | all domains released, done_o high
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int N_DOM       = 4,
   parameter int LOCK_CYCLES = 1024,
   parameter int GAP_CYCLES  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  pll_locked_i,
   input  logic                  sw_rst_req_i,
   output logic [N_DOM-1:0]      rst_n_o,
`ifdef RST_SEQ_LOSS_CNT_EN
   output logic [LOSS_CNT_W-1:0] loss_cnt_o,
`endif
   output logic                  done_o
);

   localparam int CNT_W = cnt_width(LOCK_CYCLES, GAP_CYCLES);
   localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_TC  = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             lock_s;
   logic             lock_lost;
   logic             abort_req;

   bit_syn u_lock_syn (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .d     (pll_locked_i),
      .q     (lock_s)
   );

   // Lock loss only matters once a release has started; in WAIT_LOCK it just clears cnt.
   assign lock_lost = !lock_s && (state == RELEASE || state == RUN);
   assign abort_req = (state != ASSERT) && (sw_rst_req_i || lock_lost);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state   <= ASSERT;
         cnt     <= '0;
         idx     <= '0;
         rst_n_o <= '0;
         done_o  <= 1'b0;
      end else if (abort_req) begin
         state   <= ASSERT;
         cnt     <= '0;
         idx     <= '0;
         rst_n_o <= '0;
         done_o  <= 1'b0;
      end else begin
         case (state)
            ASSERT: begin
               if (sw_rst_req_i) begin
                  cnt <= '0;
               end else if (cnt == GAP_TC) begin
                  cnt   <= '0;
                  state <= WAIT_LOCK;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            WAIT_LOCK: begin
               if (!lock_s) begin
                  cnt <= '0;
               end else if (cnt == LOCK_TC) begin
                  cnt     <= '0;
                  idx     <= '0;
                  rst_n_o <= N_DOM'(1);
                  state   <= RELEASE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            RELEASE: begin
               if (cnt == GAP_TC) begin
                  cnt <= '0;
                  if (idx == IDX_LAST) begin
                     done_o <= 1'b1;
                     state  <= RUN;
                  end else begin
                     idx     <= idx + IDX_ONE;
                     // shifting a one in keeps the output a thermometer code
                     rst_n_o <= N_DOM'({rst_n_o, 1'b1});
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            RUN: begin
               state <= RUN;
            end
            default: begin
               state <= ASSERT;
            end
         endcase
      end
   end

`ifdef RST_SEQ_LOSS_CNT_EN
   localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         loss_cnt_o <= '0;
      end else if (lock_lost && loss_cnt_o != '1) begin
         loss_cnt_o <= loss_cnt_o + LOSS_ONE;
      end
   end
`endif

endmodule
